alu_exec_unit: RTL and testbench

//  Sequential responder wrapping the ALU opcode set behind a valid/ready request/response handshake.

---
 rtl/alu_exec_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Handshaked ALU execution unit. Single-cycle logic ops, iterative
//            shift-add multiply, architectural N/Z/V/C flags register.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [3:0]         req_op,
   input  logic [WIDTH-1:0]   req_a,
   input  logic [WIDTH-1:0]   req_b,
   input  logic [SHAMT_W-1:0] req_shift,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH-1:0]   rsp_result,
   output logic [3:0]         rsp_flags,
   output logic               rsp_wb_en,
   output logic               rsp_err,
   output logic [3:0]         flags_n_z_v_c
);

   localparam logic [3:0] c_op_add = 4'd0;
   localparam logic [3:0] c_op_sub = 4'd1;
   localparam logic [3:0] c_op_mul = 4'd2;
   localparam logic [3:0] c_op_or  = 4'd3;
   localparam logic [3:0] c_op_and = 4'd4;
   localparam logic [3:0] c_op_xor = 4'd5;
   localparam logic [3:0] c_op_shr = 4'd6;
   localparam logic [3:0] c_op_shl = 4'd7;
   localparam logic [3:0] c_op_ror = 4'd8;
   localparam logic [3:0] c_op_cmp = 4'd9;

   localparam int                 c_cnt_w    = $clog2(WIDTH);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MUL_BUSY = 2'd1,
      S_DONE     = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic w_accept;
   logic w_rsp_take;
   logic w_mul_last;

   // Single-cycle datapath, evaluated on the live request inputs and
   // captured into the response registers at acceptance.
   logic [WIDTH:0]   w_add_ext;
   logic [WIDTH-1:0] w_diff;
   logic [WIDTH:0]   w_shl_ext;
   logic [WIDTH:0]   w_shr_ext;
   logic [WIDTH-1:0] w_ror;
   logic [WIDTH-1:0] w_result;
   logic             w_v;
   logic             w_c;
   logic             w_wb_en;
   logic             w_err;
   logic [3:0]       w_flags;

   // Multiplier state
   logic [2*WIDTH-1:0] r_acc;
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [c_cnt_w-1:0] r_cnt;
   logic [2*WIDTH-1:0] w_acc_step;
   logic [WIDTH-1:0]   w_mul_lo;
   logic [WIDTH-1:0]   w_mul_hi;

   // Response and architectural registers
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_flags;
   logic             r_wb_en;
   logic             r_err;
   logic [3:0]       r_flags_arch;

   assign w_accept   = req_valid & req_ready;
   assign w_rsp_take = rsp_valid & rsp_ready;

   // The extra bit on each shift vector catches the last bit shifted out;
   // a zero shift leaves it clear, giving C=0 for free.
   assign w_add_ext = {1'b0, req_a} + {1'b0, req_b};
   assign w_diff    = req_a - req_b;
   assign w_shl_ext = {1'b0, req_a} << req_shift;
   assign w_shr_ext = {req_a, 1'b0} >> req_shift;
   assign w_ror     = (req_a >> req_shift) | (req_a << (WIDTH - int'(req_shift)));

   always_comb begin
      w_result = '0;
      w_v      = 1'b0;
      w_c      = 1'b0;
      w_wb_en  = 1'b1;
      w_err    = 1'b0;
      case (req_op)
         c_op_add: begin
            w_result = w_add_ext[WIDTH-1:0];
            w_c      = w_add_ext[WIDTH];
            w_v      = (req_a[WIDTH-1] == req_b[WIDTH-1]) &&
                       (w_result[WIDTH-1] != req_a[WIDTH-1]);
         end
         c_op_sub, c_op_cmp: begin
            w_result = w_diff;
            w_c      = (req_a >= req_b);
            w_v      = (req_a[WIDTH-1] != req_b[WIDTH-1]) &&
                       (w_result[WIDTH-1] != req_a[WIDTH-1]);
            w_wb_en  = (req_op != c_op_cmp);
         end
         c_op_mul: w_result = '0;
         c_op_or:  w_result = req_a | req_b;
         c_op_and: w_result = req_a & req_b;
         c_op_xor: w_result = req_a ^ req_b;
         c_op_shr: begin
            w_result = w_shr_ext[WIDTH:1];
            w_c      = w_shr_ext[0];
         end
         c_op_shl: begin
            w_result = w_shl_ext[WIDTH-1:0];
            w_c      = w_shl_ext[WIDTH];
         end
         c_op_ror: begin
            w_result = w_ror;
            w_c      = w_ror[WIDTH-1];
         end
         default: begin
            w_wb_en = 1'b0;
            w_err   = 1'b1;
         end
      endcase
      w_flags = w_err ? 4'b0000
                      : {w_result[WIDTH-1], (w_result == '0), w_v, w_c};
   end

   // One shift-add step: multiplicand moves left, multiplier moves right.
   assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_mul_lo   = w_acc_step[WIDTH-1:0];
   assign w_mul_hi   = w_acc_step[2*WIDTH-1:WIDTH];
   assign w_mul_last = (r_cnt == c_cnt_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      req_ready    = 1'b0;
      rsp_valid    = 1'b0;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               w_state_next = (req_op == c_op_mul) ? S_MUL_BUSY : S_DONE;
            end
         end
         S_MUL_BUSY: begin
            if (w_mul_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            rsp_valid = 1'b1;
            if (rsp_ready) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc        <= '0;
         r_mcand      <= '0;
         r_mplier     <= '0;
         r_cnt        <= '0;
         r_result     <= '0;
         r_flags      <= '0;
         r_wb_en      <= 1'b0;
         r_err        <= 1'b0;
         r_flags_arch <= '0;
      end else begin
         if (w_accept) begin
            if (req_op == c_op_mul) begin
               r_acc    <= '0;
               r_mcand  <= {{WIDTH{1'b0}}, req_a};
               r_mplier <= req_b;
               r_cnt    <= '0;
            end else begin
               r_result <= w_result;
               r_flags  <= w_flags;
               r_wb_en  <= w_wb_en;
               r_err    <= w_err;
            end
         end
         if (r_state == S_MUL_BUSY) begin
            r_acc    <= w_acc_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_mul_last) begin
               r_result <= w_mul_lo;
               r_flags  <= {w_mul_lo[WIDTH-1], (w_mul_lo == '0), (|w_mul_hi), 1'b0};
               r_wb_en  <= 1'b1;
               r_err    <= 1'b0;
            end
         end
         // Illegal ops leave the architectural flags untouched.
         if (w_rsp_take && !r_err) begin
            r_flags_arch <= r_flags;
         end
      end
   end

   assign rsp_result    = r_result;
   assign rsp_flags     = r_flags;
   assign rsp_wb_en     = r_wb_en;
   assign rsp_err       = r_err;
   assign flags_n_z_v_c = r_flags_arch;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_exec_unit
// Brief    : Directed plus randomized bench for alu_exec_unit against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

   localparam int W = 32;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         req_valid = 1'b0;
   logic         rsp_ready = 1'b0;
   logic [3:0]   req_op    = '0;
   logic [W-1:0] req_a     = '0;
   logic [W-1:0] req_b     = '0;
   logic [4:0]   req_shift = '0;
   logic         req_ready;
   logic         rsp_valid;
   logic [W-1:0] rsp_result;
   logic [3:0]   rsp_flags;
   logic         rsp_wb_en;
   logic         rsp_err;
   logic [3:0]   flags_n_z_v_c;

   int         checks   = 0;
   int         failures = 0;
   logic [3:0] exp_freg = 4'b0000;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_op        (req_op),
      .req_a         (req_a),
      .req_b         (req_b),
      .req_shift     (req_shift),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_result    (rsp_result),
      .rsp_flags     (rsp_flags),
      .rsp_wb_en     (rsp_wb_en),
      .rsp_err       (rsp_err),
      .flags_n_z_v_c (flags_n_z_v_c)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain wide arithmetic on the operation definitions.
   function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] sh, output logic [31:0] r, output logic [3:0] f,
                                 output logic wb, output logic err);
      logic [63:0] s;
      logic [31:0] t;
      longint      sv;
      logic        v;
      logic        c;
      r = '0; v = 1'b0; c = 1'b0; err = 1'b0;
      case (op)
         4'd0: begin
            s  = 64'(a) + 64'(b);
            r  = s[31:0];
            c  = s[32];
            sv = longint'($signed(a)) + longint'($signed(b));
            v  = (sv != longint'($signed(r)));
         end
         4'd1, 4'd9: begin
            r  = a - b;
            c  = (a >= b);
            sv = longint'($signed(a)) - longint'($signed(b));
            v  = (sv != longint'($signed(r)));
         end
         4'd2: begin
            s = 64'(a) * 64'(b);
            r = s[31:0];
            v = (s[63:32] != 0);
         end
         4'd3: r = a | b;
         4'd4: r = a & b;
         4'd5: r = a ^ b;
         4'd6: begin
            r = a >> sh;
            if (sh != 0) begin t = a >> (sh - 1); c = t[0]; end
         end
         4'd7: begin
            r = a << sh;
            if (sh != 0) begin t = a >> (32 - int'(sh)); c = t[0]; end
         end
         4'd8: begin
            r = a;
            for (int i = 0; i < int'(sh); i++) r = {r[0], r[31:1]};
            c = r[31];
         end
         default: err = 1'b1;
      endcase
      f  = err ? 4'b0000 : {r[31], (r == 0), v, c};
      wb = !err && (op != 4'd9);
   endfunction

   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, input int bp);
      logic [31:0] er;
      logic [3:0]  ef;
      logic        ewb;
      logic        eerr;
      logic [43:0] snap;
      logic        stable;
      int          n;
      model(op, a, b, sh, er, ef, ewb, eerr);
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_shift = sh;
      @(posedge clk); #1;
      // Keep offering junk; nothing may be accepted until back in IDLE.
      req_op = 4'($urandom); req_a = $urandom; req_b = $urandom; req_shift = 5'($urandom);
      n = 0;
      while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk({tag, " latency"}, 64'(n), (op == 4'd2) ? 64'd32 : 64'd0);
      chk({tag, " req_ready"}, 64'(req_ready), 64'd0);
      snap   = {rsp_valid, req_ready, rsp_result, rsp_flags, rsp_wb_en, rsp_err, flags_n_z_v_c};
      stable = 1'b1;
      repeat (bp) begin
         @(posedge clk); #1;
         if ({rsp_valid, req_ready, rsp_result, rsp_flags, rsp_wb_en, rsp_err, flags_n_z_v_c} !== snap)
            stable = 1'b0;
      end
      if (bp > 0) chk({tag, " stable"}, 64'(stable), 64'd1);
      chk({tag, " result"}, 64'(rsp_result), 64'(er));
      chk({tag, " flags"},  64'(rsp_flags),  64'(ef));
      chk({tag, " wb_en"},  64'(rsp_wb_en),  64'(ewb));
      chk({tag, " err"},    64'(rsp_err),    64'(eerr));
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      if (!eerr) exp_freg = ef;
      chk({tag, " post rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, " post req_ready"}, 64'(req_ready), 64'd1);
      chk({tag, " flags_reg"}, 64'(flags_n_z_v_c), 64'(exp_freg));
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset req_ready", 64'(req_ready), 64'd1);
      chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset result",    64'(rsp_result), 64'd0);
      chk("reset flags",     64'(rsp_flags), 64'd0);
      chk("reset wb_en",     64'(rsp_wb_en), 64'd0);
      chk("reset err",       64'(rsp_err), 64'd0);
      chk("reset flags_reg", 64'(flags_n_z_v_c), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("add_5_1",   4'd0, 32'd5, 32'd1, 5'd0, 0);
      run_op("sub_5_1",   4'd1, 32'd5, 32'd1, 5'd0, 0);
      run_op("sub_1_5",   4'd1, 32'd1, 32'd5, 5'd0, 0);
      run_op("add_ovf",   4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 0);
      run_op("mul_5_2",   4'd2, 32'd5, 32'd2, 5'd0, 0);
      run_op("mul_wrap",  4'd2, 32'h0001_0000, 32'h0001_0000, 5'd0, 0);
      chk("mul_wrap flags literal", 64'(flags_n_z_v_c), 64'(4'b0110));
      run_op("shr_8_2",   4'd6, 32'd8, 32'd0, 5'd2, 0);
      run_op("shl_msb",   4'd7, 32'h8000_0001, 32'd0, 5'd1, 0);
      run_op("ror_1_1",   4'd8, 32'd1, 32'd0, 5'd1, 0);
      chk("ror flags literal", 64'(flags_n_z_v_c), 64'(4'b1001));
      run_op("shr_zero",  4'd6, 32'hFFFF_FFFF, 32'd0, 5'd0, 0);
      run_op("shl_31",    4'd7, 32'h0000_0003, 32'd0, 5'd31, 0);
      run_op("cmp_11_11", 4'd9, 32'd11, 32'd11, 5'd0, 0);
      chk("cmp flags literal", 64'(flags_n_z_v_c), 64'(4'b0101));
      run_op("illegal12", 4'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 0);
      chk("illegal keeps flags", 64'(flags_n_z_v_c), 64'(4'b0101));
      run_op("backpress", 4'd5, 32'hA5A5_0F0F, 32'hFFFF_0000, 5'd0, 5);
      run_op("mul_bp",    4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 3);

      // Abort a multiply partway through with an asynchronous reset.
      run_op("pre_abort", 4'd9, 32'd3, 32'd7, 5'd0, 0);
      req_valid = 1'b1; req_op = 4'd2; req_a = 32'd1234; req_b = 32'd5678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort rsp_valid", 64'(rsp_valid), 64'd0);
      chk("abort req_ready", 64'(req_ready), 64'd1);
      chk("abort flags_reg", 64'(flags_n_z_v_c), 64'd0);
      exp_freg = 4'b0000;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("add_after_rst", 4'd0, 32'd5, 32'd1, 5'd0, 0);

      for (int i = 0; i < 40; i++) begin
         op = 4'($urandom_range(0, 11));
         case ($urandom_range(0, 3))
            0:       a = 32'($urandom_range(0, 15));
            1:       a = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 3) == 0) ? a : $urandom;
         run_op($sformatf("rnd%0d", i), op, a, b, 5'($urandom), int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
